// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: operation codes and FSM states.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/arith_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
// hi/lo hold product high/low halves (MUL) or remainder/quotient (DIV) when done.
module arith_iter_core
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [CNT_W-1:0] start_cnt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             done_c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_q;
  logic             div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  // MUL: add multiplicand when the current multiplier bit is set, then shift {sum, lo} right.
  // DIV: shift next dividend bit into the partial remainder and subtract when it fits.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_shift[WIDTH-1:0] - b_q;
  end

  assign done_c = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      cnt   <= start_cnt;
      hi    <= '0;
      lo    <= a;
      b_q   <= b;
      div_q <= is_div;
    end else if (step && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
      if (div_q) begin
        hi <= div_ge ? div_rem : div_shift[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], div_ge};
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/arith_seq_unit.sv
// Handshaked unsigned ADD/SUB/MUL/DIV unit; one operation in flight.
// Optional saturation of ADD/SUB/MUL results under ARITH_SEQ_SAT_EN.
module arith_seq_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] ext,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state, state_next;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             latch;
  logic             out_valid_next, err_next, in_ready_next;
  logic [WIDTH-1:0] result_next, ext_next;

  logic             core_start, core_step, core_done_c;
  logic [CNT_W-1:0] core_cnt;
  logic [WIDTH-1:0] core_hi, core_lo;

  logic [WIDTH:0]   sum_c, diff_c;
  logic [WIDTH-1:0] res_c, ext_c;
  logic             err_c;

  arith_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .is_div    (op == OP_DIV),
    .start_cnt (core_cnt),
    .a         (a),
    .b         (b),
    .step      (core_step),
    .done_c    (core_done_c),
    .hi        (core_hi),
    .lo        (core_lo)
  );

  // Final result selection from latched operands and iterative datapath.
  always_comb begin
    sum_c  = {1'b0, a_q} + {1'b0, b_q};
    diff_c = {1'b0, a_q} - {1'b0, b_q};
    res_c  = '0;
    ext_c  = '0;
    err_c  = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        ext_c = WIDTH'(sum_c[WIDTH]);
`ifdef ARITH_SEQ_SAT_EN
        if (sum_c[WIDTH]) res_c = '1;
`endif
      end
      OP_SUB: begin
        res_c = diff_c[WIDTH-1:0];
        ext_c = WIDTH'(diff_c[WIDTH]);
`ifdef ARITH_SEQ_SAT_EN
        if (diff_c[WIDTH]) res_c = '0;
`endif
      end
      OP_MUL: begin
        res_c = core_lo;
        ext_c = core_hi;
`ifdef ARITH_SEQ_SAT_EN
        if (core_hi != '0) res_c = '1;
`endif
      end
      default: begin
        if (b_q == '0) begin
          res_c = '1;
          ext_c = a_q;
          err_c = 1'b1;
        end else begin
          res_c = core_lo;
          ext_c = core_hi;
        end
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next     = state;
    out_valid_next = out_valid;
    result_next    = result;
    ext_next       = ext;
    err_next       = err;
    latch          = 1'b0;
    core_start     = 1'b0;
    core_step      = 1'b0;
    core_cnt       = CNT_W'(1);
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          latch = 1'b1;
          if ((op == OP_DIV) && (b == '0)) begin
            state_next = ST_DONE;
          end else begin
            core_start = 1'b1;
            core_cnt   = op[1] ? CNT_W'(WIDTH) : CNT_W'(1);
            state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        core_step = 1'b1;
        if (core_done_c) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!out_valid) begin
          out_valid_next = 1'b1;
          result_next    = res_c;
          ext_next       = ext_c;
          err_next       = err_c;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    in_ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      ext       <= '0;
      err       <= 1'b0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      result    <= result_next;
      ext       <= ext_next;
      err       <= err_next;
      if (latch) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
    end
  end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Scoreboard bench for arith_seq_unit (WIDTH=8): driver pushes expectations, monitor checks results.
module tb_arith_seq_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [1:0]   op;
  logic [W-1:0] a, b, result, ext;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] ext;
    logic         err;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  arith_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ext       (ext),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: compare each rising out_valid against the oldest expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && !prev) begin
        if (sb.size() == 0) begin
          fail_now("unexpected out_valid");
        end else begin
          e = sb.pop_front();
          check({e.name, " result"}, 32'(result), 32'(e.res));
          check({e.name, " ext"}, 32'(ext), 32'(e.ext));
          check({e.name, " err"}, 32'(err), 32'(e.err));
          check({e.name, " latency edge"}, 32'(cyc), 32'(e.due));
        end
      end
      prev = out_valid;
    end
  end

  task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] er, input logic [W-1:0] ee,
                       input logic eerr, input int lat, input bit push);
    int t;
    int k;
    exp_t e;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail_now({name, " in_ready wait"});
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    k = cyc;
    in_valid = 1'b0;
    if (push) begin
      e.res = er; e.ext = ee; e.err = eerr; e.due = k + lat; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) fail_now("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset ext", 32'(ext), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("add 8+4", 2'b00, 8'd8, 8'd4, 8'd12, 8'd0, 1'b0, 2, 1);
`ifdef ARITH_SEQ_SAT_EN
    issue("add 200+100", 2'b00, 8'd200, 8'd100, 8'd255, 8'd1, 1'b0, 2, 1);
    issue("sub 4-8", 2'b01, 8'd4, 8'd8, 8'd0, 8'd1, 1'b0, 2, 1);
`else
    issue("add 200+100", 2'b00, 8'd200, 8'd100, 8'd44, 8'd1, 1'b0, 2, 1);
    issue("sub 4-8", 2'b01, 8'd4, 8'd8, 8'd252, 8'd1, 1'b0, 2, 1);
`endif
    issue("sub 8-4", 2'b01, 8'd8, 8'd4, 8'd4, 8'd0, 1'b0, 2, 1);
    issue("mul 8*4", 2'b10, 8'd8, 8'd4, 8'd32, 8'd0, 1'b0, 9, 1);
`ifdef ARITH_SEQ_SAT_EN
    issue("mul 255*255", 2'b10, 8'd255, 8'd255, 8'd255, 8'd254, 1'b0, 9, 1);
`else
    issue("mul 255*255", 2'b10, 8'd255, 8'd255, 8'd1, 8'd254, 1'b0, 9, 1);
`endif
    issue("div 8/4", 2'b11, 8'd8, 8'd4, 8'd2, 8'd0, 1'b0, 9, 1);
    issue("div 7/3", 2'b11, 8'd7, 8'd3, 8'd2, 8'd1, 1'b0, 9, 1);
    issue("div 9/0", 2'b11, 8'd9, 8'd0, 8'd255, 8'd9, 1'b1, 1, 1);
    issue("div 5/9", 2'b11, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, 1);
    issue("div 200/1", 2'b11, 8'd200, 8'd1, 8'd200, 8'd0, 1'b0, 9, 1);
    drain();

    // Backpressure: result must hold and new requests must be ignored.
    @(negedge clk);
    out_ready = 1'b0;
    issue("mul 3*5 bp", 2'b10, 8'd3, 8'd5, 8'd15, 8'd0, 1'b0, 9, 1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) fail_now("bp out_valid wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp result held", 32'(result), 32'd15);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      in_valid = 1'b1; op = 2'b00; a = 8'd1; b = 8'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release result kept", 32'(result), 32'd15);
    repeat (4) @(posedge clk);

    // Reset during DIV iterations discards the operation.
    issue("div 200/7 aborted", 2'b11, 8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 9, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst result", 32'(result), 32'd0);
    check("midrst ext", 32'(ext), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue("add 8+4 after rst", 2'b00, 8'd8, 8'd4, 8'd12, 8'd0, 1'b0, 2, 1);
    drain();
    repeat (12) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
